fft_seq_ctrl: RTL and testbench

Sequencer for an in-place radix-2 DIT FFT/IFFT over the shared data memory. On a start pulse it takes ownership of the memory and runs a bit-reversal permutation pass, then LOG2N butterfly stages. For each butterfly it issues read addresses, twiddle index and write-back addresses to the butterfly datapath. While busy, it stalls any CPU MEM-stage access so the pipeline and the FFT engine never collide on the memory.

---
 rtl/fft_seq_ctrl_pkg.sv | 17 +
 rtl/fft_addr_gen.sv | 37 +++
 rtl/fft_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fft_seq_ctrl_pkg.sv
// Shared constants and state encoding for the FFT sequencer.
package fft_seq_ctrl_pkg;

  localparam int FFT_LOG2N  = 5;
  localparam int FFT_N      = 1 << FFT_LOG2N;
  localparam int FFT_BF_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BITREV,
    ST_BR_DRAIN,
    ST_STAGE,
    ST_ST_DRAIN,
    ST_DONE
  } fft_state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address mapping (s, k) -> (a, b, twiddle) and bit reversal of the
// permutation index.
module fft_addr_gen #(
  parameter int LOG2N = 5
) (
  input  logic [LOG2N-1:0] s,
  input  logic [LOG2N-1:0] k,
  input  logic [LOG2N-1:0] i,
  output logic [LOG2N-1:0] a,
  output logic [LOG2N-1:0] b,
  output logic [LOG2N-1:0] i_rev,
  output logic [LOG2N-2:0] tw_idx
);

  localparam logic [LOG2N-1:0] ONE   = LOG2N'(1);
  localparam logic [LOG2N-1:0] S_MAX = LOG2N'(LOG2N - 1);

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int j = 0; j < LOG2N; j++) r[j] = x[LOG2N-1-j];
    return r;
  endfunction

  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;

  always_comb begin
    span   = ONE << s;
    pos    = k & (span - ONE);
    a      = ((k >> s) << (s + ONE)) | pos;
    b      = a + span;
    // pos < span, so the shifted twiddle always fits in LOG2N-1 bits
    tw_idx = (LOG2N-1)'(pos << (S_MAX - s));
    i_rev  = bit_rev(i);
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 DIT FFT sequencer: bit-reversal pass, LOG2N butterfly
// stages, write-back delay line and CPU memory-stage stall.
//
// state      | meaning
// IDLE       | waiting for start, memory owned by CPU
// BITREV     | permutation swaps, one index per cycle
// BR_DRAIN   | wait for last swap write-back
// STAGE      | butterfly issue, one pair per cycle
// ST_DRAIN   | wait for stage write-back before next stage reads
// DONE       | one-cycle completion pulse
module fft_seq_ctrl
  import fft_seq_ctrl_pkg::*;
#(
  parameter int LOG2N  = FFT_LOG2N,
  parameter int BF_LAT = FFT_BF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inverse,
  input  logic             cpu_mem_req,
  output logic             cpu_stall,
  output logic             mem_sel,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             bf_bypass,
  output logic             bf_inverse,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);
  localparam logic [LOG2N-1:0] I_LAST     = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] K_LAST     = LOG2N'(N / 2 - 1);
  localparam logic [LOG2N-1:0] S_LAST     = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] DRAIN_LOAD = LOG2N'(BF_LAT - 1);

  fft_state_e       state, state_n;
  logic [LOG2N-1:0] idx, idx_n;
  logic [LOG2N-1:0] stg, stg_n;
  logic [LOG2N-1:0] drn, drn_n;
  logic             inv_q, inv_n;

  logic [LOG2N-1:0] ag_a, ag_b, ag_rev;
  logic [LOG2N-2:0] ag_tw;
  logic [LOG2N-1:0] wa, wb;

  logic             dl_v [BF_LAT];
  logic [LOG2N-1:0] dl_a [BF_LAT];
  logic [LOG2N-1:0] dl_b [BF_LAT];

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s      (stg),
    .k      (idx),
    .i      (idx),
    .a      (ag_a),
    .b      (ag_b),
    .i_rev  (ag_rev),
    .tw_idx (ag_tw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      stg   <= '0;
      drn   <= '0;
      inv_q <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      stg   <= stg_n;
      drn   <= drn_n;
      inv_q <= inv_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    stg_n     = stg;
    drn_n     = drn;
    inv_n     = inv_q;
    rd_en     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_idx    = '0;
    bf_bypass = 1'b0;
    wa        = '0;
    wb        = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          inv_n   = inverse;
          idx_n   = '0;
          stg_n   = '0;
          state_n = ST_BITREV;
        end
      end
      ST_BITREV: begin
        // each pair is swapped once, from its smaller index
        if (ag_rev > idx) begin
          rd_en     = 1'b1;
          bf_bypass = 1'b1;
          rd_addr_a = idx;
          rd_addr_b = ag_rev;
          wa        = ag_rev;
          wb        = idx;
        end
        if (idx == I_LAST) begin
          idx_n   = '0;
          drn_n   = DRAIN_LOAD;
          state_n = ST_BR_DRAIN;
        end else begin
          idx_n = idx + ONE;
        end
      end
      ST_BR_DRAIN: begin
        if (drn == '0) begin
          stg_n   = '0;
          idx_n   = '0;
          state_n = ST_STAGE;
        end else begin
          drn_n = drn - ONE;
        end
      end
      ST_STAGE: begin
        rd_en     = 1'b1;
        rd_addr_a = ag_a;
        rd_addr_b = ag_b;
        tw_idx    = ag_tw;
        wa        = ag_a;
        wb        = ag_b;
        if (idx == K_LAST) begin
          idx_n   = '0;
          drn_n   = DRAIN_LOAD;
          state_n = ST_ST_DRAIN;
        end else begin
          idx_n = idx + ONE;
        end
      end
      ST_ST_DRAIN: begin
        if (drn != '0) begin
          drn_n = drn - ONE;
        end else if (stg == S_LAST) begin
          state_n = ST_DONE;
        end else begin
          stg_n   = stg + ONE;
          idx_n   = '0;
          state_n = ST_STAGE;
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < BF_LAT; j++) begin
        dl_v[j] <= 1'b0;
        dl_a[j] <= '0;
        dl_b[j] <= '0;
      end
    end else begin
      dl_v[0] <= rd_en;
      dl_a[0] <= wa;
      dl_b[0] <= wb;
      for (int j = 1; j < BF_LAT; j++) begin
        dl_v[j] <= dl_v[j-1];
        dl_a[j] <= dl_a[j-1];
        dl_b[j] <= dl_b[j-1];
      end
    end
  end

  assign wr_en      = dl_v[BF_LAT-1];
  assign wr_addr_a  = dl_a[BF_LAT-1];
  assign wr_addr_b  = dl_b[BF_LAT-1];
  assign busy       = (state != ST_IDLE);
  assign mem_sel    = busy;
  assign done       = (state == ST_DONE);
  assign cpu_stall  = busy & cpu_mem_req;
  assign bf_inverse = inv_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: cycle schedule built from the
// transform definition, randomized stall requests and ignored starts.
module tb_fft_seq_ctrl;

  localparam int LOG2N  = 5;
  localparam int N      = 32;
  localparam int BF_LAT = 2;
  localparam int LAT    = 1 + N + BF_LAT + LOG2N * (N / 2 + BF_LAT);
  localparam int MAXC   = LAT + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic cpu_mem_req = 1'b0;
  logic cpu_stall, mem_sel, busy, done, rd_en, bf_bypass, bf_inverse, wr_en;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_idx;

  fft_seq_ctrl #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inverse     (inverse),
    .cpu_mem_req (cpu_mem_req),
    .cpu_stall   (cpu_stall),
    .mem_sel     (mem_sel),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .tw_idx      (tw_idx),
    .bf_bypass   (bf_bypass),
    .bf_inverse  (bf_inverse),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_addr_b   (wr_addr_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int e_rd [MAXC];
  int e_ra [MAXC];
  int e_rb [MAXC];
  int e_tw [MAXC];
  int e_by [MAXC];
  int e_wr [MAXC];
  int e_wa [MAXC];
  int e_wb [MAXC];
  int e_done_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev_n(input int x);
    int r = 0;
    for (int j = 0; j < LOG2N; j++) r = r * 2 + ((x / (1 << j)) % 2);
    return r;
  endfunction

  // Expected per-cycle issue/write schedule, cycle 0 = the start cycle.
  function automatic void build_sched();
    int c;
    for (int j = 0; j < MAXC; j++) begin
      e_rd[j] = 0; e_ra[j] = 0; e_rb[j] = 0; e_tw[j] = 0; e_by[j] = 0;
      e_wr[j] = 0; e_wa[j] = 0; e_wb[j] = 0;
    end
    c = 1;
    for (int i = 0; i < N; i++) begin
      if (rev_n(i) > i) begin
        e_rd[c] = 1; e_ra[c] = i; e_rb[c] = rev_n(i); e_by[c] = 1;
        e_wr[c+BF_LAT] = 1; e_wa[c+BF_LAT] = rev_n(i); e_wb[c+BF_LAT] = i;
      end
      c++;
    end
    c += BF_LAT;
    for (int s = 0; s < LOG2N; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        int span, pos, a;
        span = 1 << s;
        pos  = k % span;
        a    = (k / span) * 2 * span + pos;
        e_rd[c] = 1; e_ra[c] = a; e_rb[c] = a + span;
        e_tw[c] = pos * ((N / 2) / span);
        e_wr[c+BF_LAT] = 1; e_wa[c+BF_LAT] = a; e_wb[c+BF_LAT] = a + span;
        c++;
      end
      c += BF_LAT;
    end
    e_done_c = c;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".cpu_stall"}, cpu_stall, 0);
    chk({tag, ".mem_sel"}, mem_sel, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".rd_en"}, rd_en, 0);
    chk({tag, ".rd_addr_a"}, rd_addr_a, 0);
    chk({tag, ".rd_addr_b"}, rd_addr_b, 0);
    chk({tag, ".tw_idx"}, tw_idx, 0);
    chk({tag, ".bf_bypass"}, bf_bypass, 0);
    chk({tag, ".bf_inverse"}, bf_inverse, 0);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".wr_addr_a"}, wr_addr_a, 0);
    chk({tag, ".wr_addr_b"}, wr_addr_b, 0);
  endtask

  // One transform; abort_c > 0 asserts reset during that cycle.
  task automatic run_xfer(input logic inv, input int abort_c);
    int br_issues = 0;
    @(posedge clk); #1;
    start = 1'b1; inverse = inv; cpu_mem_req = 1'b1;
    #1;
    chk("start.busy", busy, 0);
    chk("start.cpu_stall", cpu_stall, 0);
    for (int c = 1; c <= LAT + 2; c++) begin
      logic exp_busy;
      @(posedge clk); #1;
      start       = (c <= LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
      inverse     = 1'($urandom_range(0, 1));
      cpu_mem_req = (c == 5 || c == LAT || c == LAT + 1) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      exp_busy = (c <= e_done_c);
      chk($sformatf("c%0d.busy", c), busy, 32'(exp_busy));
      chk($sformatf("c%0d.mem_sel", c), mem_sel, 32'(exp_busy));
      chk($sformatf("c%0d.done", c), done, 32'(c == e_done_c));
      chk($sformatf("c%0d.cpu_stall", c), cpu_stall, 32'(exp_busy & cpu_mem_req));
      if (exp_busy) chk($sformatf("c%0d.bf_inverse", c), bf_inverse, 32'(inv));
      chk($sformatf("c%0d.rd_en", c), rd_en, e_rd[c]);
      if (e_rd[c] != 0) begin
        chk($sformatf("c%0d.rd_addr_a", c), rd_addr_a, e_ra[c]);
        chk($sformatf("c%0d.rd_addr_b", c), rd_addr_b, e_rb[c]);
        chk($sformatf("c%0d.bf_bypass", c), bf_bypass, e_by[c]);
        if (e_by[c] == 0) chk($sformatf("c%0d.tw_idx", c), tw_idx, e_tw[c]);
      end
      chk($sformatf("c%0d.wr_en", c), wr_en, e_wr[c]);
      if (e_wr[c] != 0) begin
        chk($sformatf("c%0d.wr_addr_a", c), wr_addr_a, e_wa[c]);
        chk($sformatf("c%0d.wr_addr_b", c), wr_addr_b, e_wb[c]);
      end
      if (c <= N && rd_en === 1'b1) br_issues++;
      if (c == N) chk("bitrev.issue_count", br_issues, 12);
      if (c == abort_c) begin
        rst = 1'b1; start = 1'b0; cpu_mem_req = 1'b1;
        #1;
        chk_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
          @(posedge clk); #1;
          cpu_mem_req = 1'($urandom_range(0, 1));
          #1;
          chk_zero($sformatf("post_abort%0d", j));
        end
        return;
      end
    end
    start = 1'b0;
    cpu_mem_req = 1'b0;
  endtask

  initial begin
    build_sched();
    cpu_mem_req = 1'b1;
    #1;
    chk_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      cpu_mem_req = 1'b1;
      #1;
      chk_zero($sformatf("idle%0d", j));
    end
    cpu_mem_req = 1'b0;

    run_xfer(1'b1, 0);
    run_xfer(1'($urandom_range(0, 1)), 1 + N + BF_LAT + 2 * (N / 2 + BF_LAT) + 5);
    run_xfer(1'($urandom_range(0, 1)), 0);
    run_xfer(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
